// File: rtl/memory_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : memory_arbiter_if
// Brief   : Fetch, data and memory buses of memory_arbiter (err only with
//           ARB_TIMEOUT_EN). master = arbiter, slave = core + memory around it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_valid;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic                  busy;
    logic                  owner;

`ifdef ARB_TIMEOUT_EN
    logic                  err;

    modport master (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, owner, err
    );

    modport slave (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, owner, err
    );
`else
    modport master (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );

    modport slave (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );
`endif
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : memory_arbiter
// Brief   : Shares one single-port memory between fetch and data requesters;
//           data has priority, fetch has a starvation guard.
//           Define ARB_TIMEOUT_EN to add a BUSY watchdog and the err output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire              clock,
    input  wire              reset,
    memory_arbiter_if.master bus
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_STARVE_ONE = c_STARVE_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("memory_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_STARVE_W-1:0] r_starve;
    logic                  r_owner;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    logic                  w_grant;
    logic                  w_grant_fetch;
    logic                  w_complete;
    logic                  w_timeout;
    logic                  w_mem_req;
    logic                  w_if_valid;
    logic                  w_dm_valid;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] w_read_data;

    // Fetch wins when alone, or once data has been favoured STARVE_LIMIT times in a row.
    assign w_grant_fetch = bus.if_req && (!bus.dm_req || (r_starve == c_STARVE_MAX));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_complete   = 1'b0;
        w_mem_req    = 1'b0;
        w_if_valid   = 1'b0;
        w_dm_valid   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.if_req || bus.dm_req) begin
                    w_grant      = 1'b1;
                    w_state_next = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready || w_timeout) begin
                    w_complete   = 1'b1;
                    w_state_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_if_valid   = ~r_owner;
                w_dm_valid   = r_owner;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve    <= '0;
            r_owner     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            if (w_grant) begin
                r_owner <= ~w_grant_fetch;
                if (w_grant_fetch) begin
                    r_mem_addr <= bus.if_addr;
                    r_mem_we   <= 1'b0;
                end else begin
                    r_mem_addr  <= bus.dm_addr;
                    r_mem_we    <= bus.dm_we;
                    r_mem_wdata <= bus.dm_wdata;
                end
                // Only a data grant that made a waiting fetch wait again counts.
                if (w_grant_fetch || !bus.if_req) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + c_STARVE_ONE;
                end
            end
            if (w_complete && !r_mem_we) begin
                if (r_owner) begin
                    r_dm_rdata <= w_read_data;
                end else begin
                    r_if_rdata <= w_read_data;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int                  c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE  = c_WDOG_W'(1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                r_err;

    // r_wdog holds the number of BUSY cycles already completed for this access.
    assign w_timeout   = !bus.mem_ready && (r_wdog == c_WDOG_LAST);
    assign w_read_data = w_timeout ? DATA_WIDTH'(32'hDEADBEEF) : bus.mem_rdata;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wdog <= '0;
            end else if (r_state == c_ST_BUSY && r_wdog != c_WDOG_LAST) begin
                r_wdog <= r_wdog + c_WDOG_ONE;
            end
            if (w_complete) begin
                r_err <= w_timeout;
            end else if (r_state == c_ST_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign w_timeout   = 1'b0;
    assign w_read_data = bus.mem_rdata;
`endif

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_valid  = w_if_valid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_valid  = w_dm_valid;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.busy      = w_busy;
    assign bus.owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module  : tb_memory_arbiter
// Brief   : Directed and random checks of memory_arbiter against a
//           transaction-level reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STARVE_LIMIT  (SL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding access at a time, a one-cycle response,
    // and a run length of data grants that overtook a waiting fetch.
    bit            m_active;
    bit            m_respond;
    bit            m_owner;
    bit            m_we;
    bit            m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_if_rdata;
    logic [DW-1:0] m_dm_rdata;
    int            m_run;
    int            m_wait;

    task automatic model_step();
        bit            fetch_wins;
        bit            timed_out;
        logic [DW-1:0] value;
        if (!reset) begin
            m_active = 0; m_respond = 0; m_owner = 0; m_we = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
            m_run = 0; m_wait = 0;
            return;
        end
        if (m_respond) begin
            m_respond = 1'b0;
            m_err     = 1'b0;
        end else if (m_active) begin
            m_wait++;
            timed_out = TIMEOUT_ON && !bus.mem_ready && (m_wait >= TO);
            if (bus.mem_ready || timed_out) begin
                m_active  = 1'b0;
                m_respond = 1'b1;
                m_err     = timed_out;
                if (!m_we) begin
                    value = timed_out ? 32'hDEADBEEF : bus.mem_rdata;
                    if (m_owner) m_dm_rdata = value;
                    else         m_if_rdata = value;
                end
            end
        end else if (bus.if_req || bus.dm_req) begin
            fetch_wins = bus.if_req && (!bus.dm_req || m_run >= SL);
            if (fetch_wins) begin
                m_owner = 1'b0; m_addr = bus.if_addr; m_we = 1'b0;
            end else begin
                m_owner = 1'b1; m_addr = bus.dm_addr; m_we = bus.dm_we;
                m_wdata = bus.dm_wdata;
            end
            if (fetch_wins || !bus.if_req) m_run = 0;
            else if (m_run < SL)           m_run++;
            m_active = 1'b1;
            m_wait   = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.busy, bus.owner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid, bus.busy, bus.owner});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_membus: got addr %h wdata %h expected 0 0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got if %h dm %h expected 0 0", bus.if_rdata, bus.dm_rdata);
        end
`ifdef ARB_TIMEOUT_EN
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", bus.err);
        end
`endif
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.dm_req = 1'b0; bus.dm_we = 1'b1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
        tick();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.owner, bus.busy, bus.if_valid} !== 5'b10010
            || bus.mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL fetch_issue: got req/we/own/busy/vld %b addr %h expected 10010 addr 00000010",
                     {bus.mem_req, bus.mem_we, bus.owner, bus.busy, bus.if_valid}, bus.mem_addr);
        end
        tick();
        checks++;
        if ({bus.mem_req, bus.if_valid, bus.dm_valid} !== 3'b010 || bus.if_rdata !== 32'h00500093) begin
            errors++;
            $display("FAIL fetch_done: got req/ifv/dmv %b rdata %h expected 010 rdata 00500093",
                     {bus.mem_req, bus.if_valid, bus.dm_valid}, bus.if_rdata);
        end
        bus.if_req = 1'b0; bus.dm_we = 1'b0;
        tick();
        checks++;
        if ({bus.if_valid, bus.busy, bus.mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL fetch_idle: got ifv/busy/req %b expected 000",
                     {bus.if_valid, bus.busy, bus.mem_req});
        end
    endtask

    task automatic test_priority();
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h18;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h2A;
        tick();
        checks++;
        if (bus.owner !== 1'b1 || bus.mem_addr !== 32'h18 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL prio_first: got owner %b addr %h req %b expected 1 00000018 1",
                     bus.owner, bus.mem_addr, bus.mem_req);
        end
        tick();
        checks++;
        if (bus.dm_valid !== 1'b1 || bus.if_valid !== 1'b0 || bus.dm_rdata !== 32'h2A) begin
            errors++;
            $display("FAIL prio_data_done: got dmv %b ifv %b dm_rdata %h expected 1 0 0000002a",
                     bus.dm_valid, bus.if_valid, bus.dm_rdata);
        end
        bus.dm_req = 1'b0; bus.mem_rdata = 32'h12345678;
        tick();
        tick();
        checks++;
        if (bus.owner !== 1'b0 || bus.mem_addr !== 32'h20 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL prio_second: got owner %b addr %h req %b expected 0 00000020 1",
                     bus.owner, bus.mem_addr, bus.mem_req);
        end
        tick();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h12345678 || bus.dm_rdata !== 32'h2A) begin
            errors++;
            $display("FAIL prio_fetch_done: got ifv %b if_rdata %h dm_rdata %h expected 1 12345678 0000002a",
                     bus.if_valid, bus.if_rdata, bus.dm_rdata);
        end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bit owners[10];
        int n_grants = 0;
        bit prev_req = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = $urandom;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = $urandom;
        bus.mem_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && n_grants < 10; cyc++) begin
            bus.mem_rdata = $urandom;
            tick();
            if (bus.mem_req === 1'b1 && !prev_req) begin
                owners[n_grants] = bus.owner;
                n_grants++;
            end
            prev_req = (bus.mem_req === 1'b1);
        end
        checks++;
        if (n_grants != 10) begin
            errors++;
            $display("FAIL starve_grant_count: got %0d grants expected 10 within 60 cycles", n_grants);
        end
        for (int i = 0; i < n_grants; i++) begin
            checks++;
            if (owners[i] !== (((i + 1) % (SL + 1)) != 0)) begin
                errors++;
                $display("FAIL starve_grant_%0d: got owner %b expected %b",
                         i, owners[i], (((i + 1) % (SL + 1)) != 0));
            end
        end
        tick();
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] addr = $urandom;
        logic [DW-1:0] final_data = $urandom;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = addr;
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.busy, bus.dm_valid} !== 4'b1010 || bus.mem_addr !== addr) begin
                errors++;
                $display("FAIL wait_hold_%0d: got req/we/busy/dmv %b addr %h expected 1010 addr %h",
                         i, {bus.mem_req, bus.mem_we, bus.busy, bus.dm_valid}, bus.mem_addr, addr);
            end
            bus.mem_ready = (i == 3);
            bus.mem_rdata = (i == 3) ? final_data : DW'($urandom);
            tick();
        end
        checks++;
        if ({bus.mem_req, bus.busy, bus.dm_valid} !== 3'b011 || bus.dm_rdata !== final_data) begin
            errors++;
            $display("FAIL wait_done: got req/busy/dmv %b dm_rdata %h expected 011 %h",
                     {bus.mem_req, bus.busy, bus.dm_valid}, bus.dm_rdata, final_data);
        end
        bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
        tick();
        checks++;
        if ({bus.dm_valid, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL wait_after: got dmv/busy %b expected 00", {bus.dm_valid, bus.busy});
        end
    endtask

    task automatic test_store();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h18;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h07;
        tick();
        tick();
        bus.dm_req = 1'b0;
        tick();
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_wdata = 32'h2A;
        bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h2A || bus.mem_addr !== 32'h18 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL store_issue: got we %b wdata %h addr %h req %b expected 1 0000002a 00000018 1",
                     bus.mem_we, bus.mem_wdata, bus.mem_addr, bus.mem_req);
        end
        tick();
        checks++;
        if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 32'h07) begin
            errors++;
            $display("FAIL store_done: got dmv %b dm_rdata %h expected 1 00000007",
                     bus.dm_valid, bus.dm_rdata);
        end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int pulses = 0;
        bus.if_req = 1'b1; bus.if_addr = $urandom; bus.mem_ready = 1'b0;
        tick();
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got mem_req %b expected 1", bus.mem_req);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1; bus.if_req = 1'b0;
        checks++;
        if ({bus.mem_req, bus.busy, bus.if_valid, bus.dm_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_abort: got req/busy/ifv/dmv %b expected 0000",
                     {bus.mem_req, bus.busy, bus.if_valid, bus.dm_valid});
        end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: got %0d active cycles expected 0", pulses);
        end
        bus.mem_ready = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cycles = 0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = $urandom; bus.mem_ready = 1'b0;
        tick();
        while (bus.mem_req === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            bus.mem_rdata = $urandom;
            tick();
        end
        checks++;
        if (busy_cycles != TO || bus.dm_valid !== 1'b1 || bus.err !== 1'b1 || bus.dm_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL timeout: got %0d busy cycles dmv %b err %b rdata %h expected %0d 1 1 deadbeef",
                     busy_cycles, bus.dm_valid, bus.err, bus.dm_rdata, TO);
        end
        bus.dm_req = 1'b0;
        tick();
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err_clear: got %b expected 0", bus.err);
        end
    endtask
`endif

    task automatic test_random();
        logic [4:0] got_ctrl;
        logic [4:0] exp_ctrl;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!bus.if_req && $urandom_range(2) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = $urandom;
            end
            if (!bus.dm_req && $urandom_range(2) == 0) begin
                bus.dm_req = 1'b1; bus.dm_we = $urandom_range(1) == 1;
                bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
            end
            bus.mem_ready = $urandom_range(2) != 0;
            bus.mem_rdata = $urandom;
            tick();
            got_ctrl = {bus.mem_req, bus.if_valid, bus.dm_valid, bus.busy, bus.owner};
            exp_ctrl = {m_active, m_respond && !m_owner, m_respond && m_owner,
                        m_active || m_respond, m_owner};
            checks++;
            if (got_ctrl !== exp_ctrl) begin
                errors++;
                if (errors < 30)
                    $display("FAIL rand_ctrl cyc %0d: got req/ifv/dmv/busy/own %b expected %b",
                             cyc, got_ctrl, exp_ctrl);
            end
            if (m_active) begin
                checks++;
                if (bus.mem_we !== m_we || bus.mem_addr !== m_addr || (m_we && bus.mem_wdata !== m_wdata)) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL rand_membus cyc %0d: got we %b addr %h wdata %h expected %b %h %h",
                                 cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, m_we, m_addr, m_wdata);
                end
            end
            checks++;
            if (bus.if_rdata !== m_if_rdata || bus.dm_rdata !== m_dm_rdata) begin
                errors++;
                if (errors < 30)
                    $display("FAIL rand_rdata cyc %0d: got if %h dm %h expected %h %h",
                             cyc, bus.if_rdata, bus.dm_rdata, m_if_rdata, m_dm_rdata);
            end
`ifdef ARB_TIMEOUT_EN
            checks++;
            if (bus.err !== m_err) begin
                errors++;
                if (errors < 30)
                    $display("FAIL rand_err cyc %0d: got %b expected %b", cyc, bus.err, m_err);
            end
`endif
            if (m_respond && !m_owner) bus.if_req = 1'b0;
            if (m_respond &&  m_owner) bus.dm_req = 1'b0;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_wait_states();
        test_store();
        test_reset_mid_access();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected $finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
